// File: rtl/wr_frame_writer.sv
// wr_frame_writer: buffers-one-burst-then-request frame writer for one wr_ctrl port.
// Rotates through NUM_FRAMES frame buffers and reports the last fully written one.
module wr_frame_writer #(
    parameter int                         CTRL_ADDR_WIDTH = 28,
    parameter int                         MEM_DQ_WIDTH    = 16,
    parameter int                         BURST_LEN       = 16,
    parameter logic [CTRL_ADDR_WIDTH-1:0] BURST_ADDR_INC  = 128,
    parameter int                         FRAME_BURSTS    = 7200,
    parameter logic [CTRL_ADDR_WIDTH-1:0] BASE_ADDR       = '0,
    parameter logic [CTRL_ADDR_WIDTH-1:0] FRAME_STRIDE    = 28'h0100000,
    parameter int                         NUM_FRAMES      = 3,
    parameter logic [3:0]                 WR_ID           = 4'd0,
    parameter int                         FIFO_CNT_W      = 10
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         frame_start_i,
    input  logic [FIFO_CNT_W-1:0]        fifo_rd_cnt_i,
    input  logic [MEM_DQ_WIDTH*8-1:0]    fifo_rd_data_i,
    output logic                         fifo_rd_en_o,
    output logic                         wr_req_o,
    input  logic                         wr_grant_i,
    output logic                         wr_en_o,
    output logic [CTRL_ADDR_WIDTH-1:0]   wr_addr_o,
    output logic [3:0]                   wr_id_o,
    output logic [3:0]                   wr_len_o,
    input  logic                         wr_ready_i,
    output logic [MEM_DQ_WIDTH*8-1:0]    wr_data_o,
    input  logic                         wr_cmd_done_i,
    output logic                         wr_done_o,
    output logic                         frame_done_o,
    output logic [1:0]                   frame_idx_o,
    output logic [1:0]                   last_frame_idx_o,
    output logic                         frame_drop_o,
    output logic [2:0]                   state_o
);
    // Handshake: wr_req is held until wr_grant is seen high on a rising edge;
    // wr_en is then a single-cycle command strobe; in DATA every cycle with
    // wr_ready high transfers (and pops) one beat; wr_cmd_done closes the burst.

    localparam int                BC_W       = (FRAME_BURSTS > 1) ? $clog2(FRAME_BURSTS) : 1;
    localparam logic [BC_W-1:0]   LAST_BURST = BC_W'(FRAME_BURSTS - 1);
    localparam logic [1:0]        LAST_IDX   = 2'(NUM_FRAMES - 1);
    localparam logic [5:0]        BEATS      = 6'(BURST_LEN);
    localparam logic [FIFO_CNT_W-1:0] CNT_BURST = FIFO_CNT_W'(BURST_LEN);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_CMD  = 3'd2,
        S_DATA = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t                       state_q, state_d;
    logic [CTRL_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [BC_W-1:0]              burst_q, burst_d;
    logic [5:0]                   beat_q, beat_d;
    logic [1:0]                   idx_q, idx_d;
    logic [1:0]                   last_q, last_d;
    logic                         drop_q, drop_d;
    logic                         armed_q, armed_d;
    logic                         pending_q, pending_d;

    logic [1:0]                   next_idx;
    logic [CTRL_ADDR_WIDTH-1:0]   next_base;
    logic [5:0]                   beat_eff;
    logic                         restart;

    assign next_idx  = (idx_q == LAST_IDX) ? 2'd0 : idx_q + 2'd1;
    assign next_base = BASE_ADDR + CTRL_ADDR_WIDTH'(next_idx) * FRAME_STRIDE;
    // A beat accepted in the same cycle as wr_cmd_done still counts.
    assign beat_eff  = beat_q + {5'd0, wr_ready_i};
    // A restart pending from earlier, or one arriving in DONE mid-frame.
    assign restart   = pending_q | (frame_start_i & (burst_q != '0));

    // Next-state, counter updates and strobes.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        burst_d      = burst_q;
        beat_d       = beat_q;
        idx_d        = idx_q;
        last_d       = last_q;
        drop_d       = drop_q;
        armed_d      = armed_q;
        pending_d    = pending_q;
        fifo_rd_en_o = 1'b0;
        wr_req_o     = 1'b0;
        wr_en_o      = 1'b0;
        wr_done_o    = 1'b0;
        frame_done_o = 1'b0;

        if (frame_start_i) begin
            if (burst_q == '0) armed_d   = 1'b1;
            else               pending_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (armed_q && (fifo_rd_cnt_i >= CNT_BURST)) state_d = S_REQ;
            end
            S_REQ: begin
                wr_req_o = 1'b1;
                if (wr_grant_i) state_d = S_CMD;
            end
            S_CMD: begin
                wr_en_o = 1'b1;
                beat_d  = '0;
                state_d = S_DATA;
            end
            S_DATA: begin
                fifo_rd_en_o = wr_ready_i;
                if (wr_ready_i && (beat_q != '1)) beat_d = beat_q + 6'd1;
                if (wr_cmd_done_i) begin
                    if (beat_eff != BEATS) drop_d = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                wr_done_o = 1'b1;
                beat_d    = '0;
                state_d   = S_IDLE;
                if (restart) begin
                    drop_d    = 1'b1;
                    idx_d     = next_idx;
                    addr_d    = next_base;
                    burst_d   = '0;
                    pending_d = 1'b0;
                    armed_d   = 1'b1;
                end else if (burst_q == LAST_BURST) begin
                    frame_done_o = 1'b1;
                    last_d       = idx_q;
                    idx_d        = next_idx;
                    addr_d       = next_base;
                    burst_d      = '0;
                    armed_d      = 1'b0;
                end else begin
                    addr_d  = addr_q + BURST_ADDR_INC;
                    burst_d = burst_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and counter registers with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            addr_q    <= BASE_ADDR;
            burst_q   <= '0;
            beat_q    <= '0;
            idx_q     <= 2'd0;
            last_q    <= LAST_IDX;
            drop_q    <= 1'b0;
            armed_q   <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            burst_q   <= burst_d;
            beat_q    <= beat_d;
            idx_q     <= idx_d;
            last_q    <= last_d;
            drop_q    <= drop_d;
            armed_q   <= armed_d;
            pending_q <= pending_d;
        end
    end

    assign wr_addr_o        = addr_q;
    assign wr_id_o          = WR_ID;
    assign wr_len_o         = 4'(BURST_LEN - 1);
    assign wr_data_o        = fifo_rd_data_i;
    assign frame_idx_o      = idx_q;
    assign last_frame_idx_o = last_q;
    assign frame_drop_o     = drop_q;
    assign state_o          = state_q;
endmodule
